register_bus_master: RTL and testbench

- Host-side command decoder that turns a byte stream from the host RX FIFO into transactions on the shared 8-bit register bus (address/data/rd/wr).
- Sits directly upstream of all register, register_constant, register_fifo_rd and register_fifo_wr instances.
- Read bytes are pushed into the host TX FIFO.
- Supports burst reads/writes with optional address auto-increment, plus a stall timeout that resynchronises the parser.

---
 rtl/regbus_pkg.sv | 19 +
 rtl/register_bus_master_if.sv | 31 +++
 rtl/register_bus_master.sv | 126 ++++++++++++
 tb/tb_register_bus_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbus_pkg.sv
// Shared definitions for the host-side register bus: command byte layout,
// bus widths and the master's parser states.
package regbus_pkg;

   localparam int CMD_WRITE_BIT = 7;
   localparam int CMD_INC_BIT   = 6;
   localparam int CMD_COUNT_W   = 6;

   localparam int REG_ADDR_W = 8;
   localparam int REG_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA
   } state_e;

endpackage

// File: rtl/register_bus_master_if.sv
// Host FIFO handshakes plus the shared 8-bit register bus (address/data/rd/wr)
// bundled for the bus master and whatever sits on the other side.
interface register_bus_master_if;
   import regbus_pkg::*;

   logic [7:0]            rx_data;
   logic                  rx_empty;
   logic                  rx_rdreq;
   logic [7:0]            tx_data;
   logic                  tx_wrreq;
   logic                  tx_full;
   logic [REG_ADDR_W-1:0] address;
   wire  [REG_DATA_W-1:0] data;
   logic                  rd;
   logic                  wr;
   logic                  busy;
   logic                  timeout_err;

   modport master (
      input  rx_data, rx_empty, tx_full,
      output rx_rdreq, tx_data, tx_wrreq, address, rd, wr, busy, timeout_err,
      inout  data
   );

   modport slave (
      output rx_data, rx_empty, tx_full,
      input  rx_rdreq, tx_data, tx_wrreq, address, rd, wr, busy, timeout_err,
      inout  data
   );

endinterface

// File: rtl/register_bus_master.sv
// Decodes CMD/ADDR/data bytes from the host RX FIFO into register bus bursts;
// read bytes pass straight from the bus into the host TX FIFO.
module register_bus_master
   import regbus_pkg::*;
#(
   parameter logic [15:0] TIMEOUT   = 16'd50000,
   parameter int          TIMEOUT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   register_bus_master_if.master   bus
);

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 16'd1);

   state_e                  state_q;
   logic                    write_q;
   logic                    inc_q;
   logic [CMD_COUNT_W-1:0]  cnt_q;
   logic [REG_ADDR_W-1:0]   address_q;
   logic [REG_ADDR_W-1:0]   wr_addr_q;
   logic [REG_DATA_W-1:0]   data_q;
   logic                    wr_q;
   logic                    timeout_err_q;
   logic [TIMEOUT_W-1:0]    tmr_q;

   logic                    pop;
   logic                    rd_go;
   logic                    stall;
   logic                    expire;
   logic [REG_ADDR_W-1:0]   addr_next_d;
   logic                    last_d;

   // A trailing wr pulse owns the bus, so IDLE holds off the next CMD for it.
   always_comb begin
      pop = 1'b0;
      unique case (state_q)
         ST_IDLE:           pop = !bus.rx_empty && !wr_q;
         ST_ADDR, ST_WDATA: pop = !bus.rx_empty;
         default:           pop = 1'b0;
      endcase
   end

   assign rd_go       = (state_q == ST_RDATA) && !bus.tx_full;
   assign stall       = ((state_q == ST_ADDR) || (state_q == ST_WDATA)) && bus.rx_empty;
   assign expire      = stall && (tmr_q == TMO_LAST);
   assign addr_next_d = inc_q ? address_q + 8'd1 : address_q;
   assign last_d      = (cnt_q == '0);

   assign bus.rx_rdreq    = pop;
   assign bus.rd          = rd_go;
   assign bus.tx_wrreq    = rd_go;
   assign bus.tx_data     = rd_go ? bus.data : 8'h00;
   assign bus.wr          = wr_q;
   assign bus.address     = wr_q ? wr_addr_q : address_q;
   assign bus.data        = wr_q ? data_q : 'z;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.timeout_err = timeout_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         write_q       <= 1'b0;
         inc_q         <= 1'b0;
         cnt_q         <= '0;
         address_q     <= '0;
         wr_addr_q     <= '0;
         data_q        <= '0;
         wr_q          <= 1'b0;
         timeout_err_q <= 1'b0;
         tmr_q         <= '0;
      end else begin
         wr_q          <= 1'b0;
         timeout_err_q <= 1'b0;

         if (pop || !stall)
            tmr_q <= '0;
         else
            tmr_q <= tmr_q + 1'b1;

         unique case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  write_q <= bus.rx_data[CMD_WRITE_BIT];
                  inc_q   <= bus.rx_data[CMD_INC_BIT];
                  cnt_q   <= bus.rx_data[CMD_COUNT_W-1:0];
                  state_q <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (pop) begin
                  address_q <= bus.rx_data;
                  state_q   <= write_q ? ST_WDATA : ST_RDATA;
               end else if (expire) begin
                  state_q       <= ST_IDLE;
                  timeout_err_q <= 1'b1;
               end
            end
            ST_WDATA: begin
               if (pop) begin
                  data_q    <= bus.rx_data;
                  wr_q      <= 1'b1;
                  wr_addr_q <= address_q;
                  address_q <= addr_next_d;
                  cnt_q     <= cnt_q - 1'b1;
                  if (last_d)
                     state_q <= ST_IDLE;
               end else if (expire) begin
                  state_q       <= ST_IDLE;
                  timeout_err_q <= 1'b1;
               end
            end
            ST_RDATA: begin
               if (rd_go) begin
                  address_q <= addr_next_d;
                  cnt_q     <= cnt_q - 1'b1;
                  if (last_d)
                     state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_register_bus_master.sv
// Directed and randomized bursts against a host/register-file model that
// predicts bus writes and TX bytes from the command byte rules.
module tb_register_bus_master;
   import regbus_pkg::*;

   localparam logic [15:0] TMO = 16'd20;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   register_bus_master_if bus();

   register_bus_master #(.TIMEOUT(TMO), .TIMEOUT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]  rx_q[$];
   logic [7:0]  wd[$];
   logic [7:0]  sl_fifo[$];
   logic [7:0]  ref_fifo[$];
   logic [15:0] got_wr[$], exp_wr[$], got_tx[$], exp_tx[$];
   int          wr_cyc[$];
   logic [7:0]  slave_mem [256];
   logic [7:0]  ref_mem   [256];
   logic [7:0]  sl_head = 8'hEE;
   logic [7:0]  sl_val;
   logic        probe = 1'b0;
   logic        hold = 1'b0, gaps = 1'b0, full_force = 1'b0, rnd_full = 1'b0;
   int          cyc = 0, to_cnt = 0, to_cyc = 0, last_pop_cyc = 0, n_rd = 0;

   logic        s_pop, s_rd, s_wr, s_tx, s_to;
   logic [7:0]  s_addr, s_wd, s_txd;

   // Register file at every address except 8'h20, which is a read FIFO.
   always_comb sl_val = (bus.address == 8'h20) ? sl_head : slave_mem[bus.address];
   assign bus.data = probe ? 8'h5A : (bus.rd ? sl_val : 8'hzz);

   task automatic chk(string tag, int obs, int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.rx_empty = (rx_q.size() == 0) || hold;
      bus.rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      bus.tx_full  = full_force || rnd_full;
      sl_head      = (sl_fifo.size() != 0) ? sl_fifo[0] : 8'hEE;
   endtask

   task automatic tick();
      @(negedge clk);
      s_pop = bus.rx_rdreq; s_rd = bus.rd; s_wr = bus.wr; s_tx = bus.tx_wrreq;
      s_to = bus.timeout_err; s_addr = bus.address; s_wd = bus.data; s_txd = bus.tx_data;
      chk("rd_wr_excl", int'(s_rd & s_wr), 0);
      chk("rxpop_when_empty", int'(s_pop & bus.rx_empty), 0);
      chk("txpush_when_full", int'(s_tx & bus.tx_full), 0);
      if (s_wr) begin got_wr.push_back({s_addr, s_wd}); wr_cyc.push_back(cyc); end
      if (s_tx) got_tx.push_back({s_addr, s_txd});
      if (s_rd) n_rd++;
      if (s_to) begin to_cnt++; to_cyc = cyc; end
      if (s_pop) last_pop_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      if (s_pop) void'(rx_q.pop_front());
      if (s_wr) slave_mem[s_addr] = s_wd;
      if (s_rd && s_addr == 8'h20 && sl_fifo.size() != 0) void'(sl_fifo.pop_front());
      hold     = gaps && ($urandom_range(0, 3) == 0);
      rnd_full = gaps && ($urandom_range(0, 3) == 0);
      drive();
   endtask

   task automatic push_cmd(bit w, bit inc, int cnt, logic [7:0] a);
      logic [5:0] c;
      c = 6'(cnt - 1);
      rx_q.push_back({w, inc, c});
      rx_q.push_back(a);
      drive();
   endtask

   task automatic wr_burst(bit inc, logic [7:0] a);
      logic [7:0] aa;
      push_cmd(1'b1, inc, wd.size(), a);
      for (int i = 0; i < wd.size(); i++) begin
         aa = inc ? 8'(a + i) : a;
         rx_q.push_back(wd[i]);
         exp_wr.push_back({aa, wd[i]});
         ref_mem[aa] = wd[i];
      end
      drive();
   endtask

   task automatic rd_burst(bit inc, int cnt, logic [7:0] a);
      logic [7:0] aa, v;
      push_cmd(1'b0, inc, cnt, a);
      for (int i = 0; i < cnt; i++) begin
         aa = inc ? 8'(a + i) : a;
         if (aa == 8'h20) v = (ref_fifo.size() != 0) ? ref_fifo.pop_front() : 8'hEE;
         else             v = ref_mem[aa];
         exp_tx.push_back({aa, v});
      end
   endtask

   task automatic wait_done(string tag, int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         done = (rx_q.size() == 0) && !bus.busy && !bus.wr;
      end
      chk({tag, "_done"}, int'(done), 1);
      tick();
   endtask

   task automatic check_logs(string tag);
      chk({tag, "_nwr"}, got_wr.size(), exp_wr.size());
      chk({tag, "_ntx"}, got_tx.size(), exp_tx.size());
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         chk({tag, "_wr"}, int'(got_wr[i]), int'(exp_wr[i]));
      for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
         chk({tag, "_tx"}, int'(got_tx[i]), int'(exp_tx[i]));
      got_wr.delete(); exp_wr.delete(); got_tx.delete(); exp_tx.delete(); wr_cyc.delete();
      n_rd = 0;
   endtask

   initial begin
      bit ok;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]   = 8'($urandom);
         slave_mem[i] = ref_mem[i];
      end
      drive();
      #12;
      chk("rst_rx_rdreq", int'(bus.rx_rdreq), 0);
      chk("rst_tx_wrreq", int'(bus.tx_wrreq), 0);
      chk("rst_tx_data", int'(bus.tx_data), 0);
      chk("rst_address", int'(bus.address), 0);
      chk("rst_rd", int'(bus.rd), 0);
      chk("rst_wr", int'(bus.wr), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_timeout_err", int'(bus.timeout_err), 0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // single write
      wd = {8'hA5};
      wr_burst(1'b0, 8'h12);
      wait_done("single_wr", 50);
      check_logs("single_wr");

      // incrementing burst write across the 8'hFF wrap
      wd = {8'h01, 8'h02, 8'h03};
      wr_burst(1'b1, 8'hFE);
      wait_done("burst_wr", 50);
      chk("burst_wr_consecutive", (wr_cyc.size() == 3) ? wr_cyc[2] - wr_cyc[0] : -1, 2);
      check_logs("burst_wr");

      // non-incrementing burst read from the FIFO register
      sl_fifo = {8'h11, 8'h22, 8'h33}; ref_fifo = {8'h11, 8'h22, 8'h33}; drive();
      rd_burst(1'b0, 3, 8'h20);
      wait_done("fifo_rd", 50);
      chk("fifo_rd_pulses", n_rd, 3);
      chk("fifo_rd_empty", sl_fifo.size(), 0);
      check_logs("fifo_rd");

      // same read with TX backpressure after the first byte
      sl_fifo = {8'h11, 8'h22, 8'h33}; ref_fifo = {8'h11, 8'h22, 8'h33}; drive();
      rd_burst(1'b0, 3, 8'h20);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = (got_tx.size() >= 1); end
      chk("bp_first_byte", int'(ok), 1);
      full_force = 1'b1; drive();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_stall_rd", int'(s_rd), 0);
      end
      full_force = 1'b0; drive();
      wait_done("bp_rd", 50);
      chk("bp_rd_pulses", n_rd, 3);
      chk("bp_fifo_empty", sl_fifo.size(), 0);
      check_logs("bp_rd");

      // timeout on a write whose data never arrives
      to_cnt = 0;
      push_cmd(1'b1, 1'b0, 2, 8'h30);
      for (int i = 0; i < 40; i++) tick();
      chk("to_pulses", to_cnt, 1);
      chk("to_latency_ok", int'((to_cyc - last_pop_cyc) >= 20 && (to_cyc - last_pop_cyc) <= 22), 1);
      chk("to_busy", int'(bus.busy), 0);
      chk("to_nwr", got_wr.size(), 0);
      rd_burst(1'b0, 1, 8'h30);
      wait_done("to_rd", 50);
      check_logs("to_rd");

      // randomized bursts with RX gaps and TX backpressure
      gaps = 1'b1;
      for (int t = 0; t < 25; t++) begin
         int cnt;
         logic [7:0] a;
         bit inc;
         cnt = $urandom_range(1, 8);
         a   = 8'($urandom_range(33, 240));
         inc = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            wd.delete();
            for (int i = 0; i < cnt; i++) wd.push_back(8'($urandom));
            wr_burst(inc, a);
         end else begin
            rd_burst(inc, cnt, a);
         end
         wait_done("rand", 400);
         check_logs("rand");
      end
      gaps = 1'b0; hold = 1'b0; rnd_full = 1'b0; drive();
      tick();

      // asynchronous reset in the middle of a write burst
      wd = {8'hD0, 8'hD1, 8'hD2, 8'hD3};
      wr_burst(1'b1, 8'h40);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = s_wr; end
      chk("mid_burst_wr_seen", int'(ok), 1);
      chk("mid_burst_wr_high", int'(bus.wr), 1);
      reset = 1'b1;
      #1;
      chk("arst_wr", int'(bus.wr), 0);
      chk("arst_rd", int'(bus.rd), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_address", int'(bus.address), 0);
      rx_q.delete(); drive();
      probe = 1'b1;
      #1;
      chk("arst_data_released", int'(bus.data), 8'h5A);
      probe = 1'b0;
      got_wr.delete(); exp_wr.delete(); wr_cyc.delete();
      tick(); tick();
      reset = 1'b0;
      tick();
      wd = {8'h77};
      wr_burst(1'b0, 8'h10);
      wait_done("post_rst_wr", 50);
      rd_burst(1'b1, 2, 8'h10);
      wait_done("post_rst_rd", 50);
      check_logs("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
